// File: rtl/reg_shift_sequencer_pkg.sv
// Shared definitions for the ARM operand-2 register-shift path.
// Contents:
//   SH_LSL/SH_LSR/SH_ASR/SH_ROR - shift_type encodings, shared with the
//                                 Val2 generator and the decoder
//   seq_state_t                 - sequencer states IDLE/SHIFT/DONE
//   eff_count()                 - clamps Rs[7:0] to the number of single-bit
//                                 steps that gives the ARM result
package arm_pkg;

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;
  localparam logic [1:0] SH_ROR = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } seq_state_t;

  // Any count of 33 or more on LSL/LSR ends with zero in the value and zero
  // in the carry. Any count of 32 or more on ASR ends with a full sign fill.
  // ROR repeats every 32, so only the low five bits matter. A nonzero
  // multiple of 32 still has to rotate once through, because the carry must
  // pick up rm[31].
  function automatic logic [5:0] eff_count(input logic [7:0] amt,
                                           input logic [1:0] typ);
    logic [5:0] n;
    n = 6'd0;
    case (typ)
      SH_LSL, SH_LSR: n = (amt > 8'd33) ? 6'd33 : amt[5:0];
      SH_ASR:         n = (amt > 8'd32) ? 6'd32 : amt[5:0];
      default: begin
        if (amt[4:0] == 5'd0 && amt != 8'd0) n = 6'd32;
        else                                 n = {1'b0, amt[4:0]};
      end
    endcase
    return n;
  endfunction

endpackage

// File: rtl/reg_shift_sequencer_shift_step.sv
// shift_step: one combinational shift pass of 0..STEP bit positions.
// Ports:
//   value[31:0]     - operand
//   amount[AW-1:0]  - positions to shift this pass (0..STEP)
//   shift_type[1:0] - LSL/LSR/ASR/ROR
//   carry_in        - carry passed through when amount is 0
//   value_out[31:0] - shifted operand
//   carry_out       - last bit shifted out (ROR: new bit 31)
module shift_step
  import arm_pkg::*;
#(
  parameter int STEP = 4,
  localparam int AW  = $clog2(STEP + 1)
) (
  input  logic [31:0]   value,
  input  logic [AW-1:0] amount,
  input  logic [1:0]    shift_type,
  input  logic          carry_in,
  output logic [31:0]   value_out,
  output logic          carry_out
);

  logic [5:0]         k;
  logic [32:0]        lsl_ext;
  logic [32:0]        lsr_ext;
  logic signed [32:0] asr_ext;
  logic [31:0]        ror_val;

  // Each shift carries one extra guard bit, so the last bit shifted out
  // lands at a fixed position. That avoids a variable bit-select.
  always_comb begin
    k       = 6'(amount);
    lsl_ext = {1'b0, value} << k;
    lsr_ext = {value, 1'b0} >> k;
    asr_ext = $signed({value, 1'b0}) >>> k;
    ror_val = (value >> k) | (value << (6'd32 - k));

    value_out = value;
    carry_out = carry_in;
    if (k != 6'd0) begin
      case (shift_type)
        SH_LSL: begin value_out = lsl_ext[31:0]; carry_out = lsl_ext[32]; end
        SH_LSR: begin value_out = lsr_ext[32:1]; carry_out = lsr_ext[0];  end
        SH_ASR: begin value_out = asr_ext[32:1]; carry_out = asr_ext[0];  end
        default: begin value_out = ror_val;      carry_out = ror_val[31]; end
      endcase
    end
  end

endmodule

// File: rtl/reg_shift_sequencer.sv
// reg_shift_sequencer: multi-cycle shifter for register-specified shifts
// (amount from Rs[7:0]). It feeds operand 2 of EXE and holds the pipeline
// through stall while it works.
// Ports:
//   clk, rst (async, active-low)
//   start, flush           - request (sampled in IDLE) / abort
//   rm[31:0], rs_amt[7:0]  - value and shift amount, latched at start
//   shift_type[1:0]        - LSL/LSR/ASR/ROR, latched at start
//   carry_in               - CPSR C, used when the effective count is 0
//   result[31:0]           - shifted value, held until the next completion
//   carry_out              - shifter carry, valid with result
//   done                   - one-cycle completion pulse
//   busy                   - high in SHIFT and DONE
//   stall                  - (start & IDLE & !flush) | SHIFT
// Optional: define REG_SHIFT_SEQ_PERF_CNT_EN to add stall_cycles[15:0].
// That counter is saturating and counts each edge with stall high.
module reg_shift_sequencer
  import arm_pkg::*;
#(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic [31:0] rm,
  input  logic [7:0]  rs_amt,
  input  logic [1:0]  shift_type,
  input  logic        carry_in,
  output logic [31:0] result,
  output logic        carry_out,
  output logic        done,
  output logic        busy,
  output logic        stall
`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
  ,
  output logic [15:0] stall_cycles
`endif
);

  localparam int AW = $clog2(STEP + 1);

  seq_state_t      state, state_nxt;
  logic [31:0]     work_reg;
  logic [5:0]      remaining;
  logic            carry_reg;
  logic [1:0]      type_reg;
  logic [5:0]      n_start;
  logic            take;
  logic            last_step;
  logic [AW-1:0]   step_amt;
  logic [31:0]     step_val;
  logic            step_c;

  assign n_start   = eff_count(rs_amt, shift_type);
  assign take      = start && !flush && (state == IDLE);
  assign last_step = (remaining <= 6'(STEP));
  assign step_amt  = last_step ? AW'(remaining) : AW'(STEP);

  shift_step #(.STEP(STEP)) u_step (
    .value      (work_reg),
    .amount     (step_amt),
    .shift_type (type_reg),
    .carry_in   (carry_reg),
    .value_out  (step_val),
    .carry_out  (step_c)
  );

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (start) state_nxt = (n_start == 6'd0) ? DONE : SHIFT;
        SHIFT:   if (last_step) state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Outputs
  always_comb begin
    busy  = (state != IDLE);
    done  = (state == DONE);
    stall = take || (state == SHIFT);
  end

  // Datapath: load at start, then one step per SHIFT edge. result and
  // carry_out are written only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      work_reg  <= '0;
      remaining <= '0;
      carry_reg <= 1'b0;
      type_reg  <= SH_LSL;
      result    <= '0;
      carry_out <= 1'b0;
    end else if (take) begin
      work_reg  <= rm;
      remaining <= n_start;
      carry_reg <= carry_in;
      type_reg  <= shift_type;
      if (n_start == 6'd0) begin
        result    <= rm;
        carry_out <= carry_in;
      end
    end else if (state == SHIFT && !flush) begin
      work_reg  <= step_val;
      carry_reg <= step_c;
      remaining <= remaining - 6'(step_amt);
      if (last_step) begin
        result    <= step_val;
        carry_out <= step_c;
      end
    end
  end

`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stall_cycles <= '0;
    else if (stall && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
  end
`endif

endmodule

// File: tb/tb_reg_shift_sequencer.sv
// Testbench for reg_shift_sequencer.
// The stimulus branch pushes the expected result, carry and done cycle.
// Those values come from the ARM shifter definition.
// A monitor branch pops one entry on every done pulse and compares it.
module tb_reg_shift_sequencer;
  localparam int STEP = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] rm = '0;
  logic [7:0]  rs_amt = '0;
  logic [1:0]  shift_type = '0;
  logic        carry_in = 1'b0;
  logic [31:0] result;
  logic        carry_out;
  logic        done;
  logic        busy;
  logic        stall;
`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
  logic [15:0] stall_cycles;
`endif

  reg_shift_sequencer #(.STEP(STEP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .flush      (flush),
    .rm         (rm),
    .rs_amt     (rs_amt),
    .shift_type (shift_type),
    .carry_in   (carry_in),
    .result     (result),
    .carry_out  (carry_out),
    .done       (done),
    .busy       (busy),
    .stall      (stall)
`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] res;
    logic        c;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ARM register-specified shift, written directly from the architecture rules.
  task automatic arm_shift(input logic [31:0] a, input logic [7:0] amt,
                           input logic [1:0] t, input logic cin,
                           output logic [31:0] r, output logic c);
    int n, s;
    n = int'(amt);
    r = a;
    c = cin;
    if (n != 0) begin
      case (t)
        2'd0: if (n < 32) begin r = a << n; c = a[32-n]; end
              else begin r = 0; c = (n == 32) ? a[0] : 1'b0; end
        2'd1: if (n < 32) begin r = a >> n; c = a[n-1]; end
              else begin r = 0; c = (n == 32) ? a[31] : 1'b0; end
        2'd2: if (n < 32) begin r = 32'($signed(a) >>> n); c = a[n-1]; end
              else begin r = {32{a[31]}}; c = a[31]; end
        default: begin
          s = n % 32;
          if (s == 0) begin r = a; c = a[31]; end
          else begin r = (a >> s) | (a << (32 - s)); c = a[s-1]; end
        end
      endcase
    end
  endtask

  // The number of done cycles after the start cycle follows from the clamped bit count.
  function automatic int latency(input logic [7:0] amt, input logic [1:0] t);
    int n;
    n = int'(amt);
    case (t)
      2'd0, 2'd1: if (n > 33) n = 33;
      2'd2:       if (n > 32) n = 32;
      default:    n = (n == 0) ? 0 : ((n % 32 == 0) ? 32 : n % 32);
    endcase
    return (n == 0) ? 1 : (n + STEP - 1) / STEP + 1;
  endfunction

  task automatic issue(input logic [31:0] a, input logic [7:0] amt,
                       input logic [1:0] t, input logic cin, input bit expect_it);
    exp_t e;
    @(negedge clk);
    rm = a; rs_amt = amt; shift_type = t; carry_in = cin; start = 1'b1;
    if (expect_it) begin
      arm_shift(a, amt, t, cin, e.res, e.c);
      e.cyc = cyc + latency(amt, t);
      exp_q.push_back(e);
    end
    #1 chk("stall_on_start", 32'(stall), 32'd1);
  endtask

  task automatic wait_done(input bit noise);
    bit got;
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        rm = $urandom; rs_amt = 8'($urandom); shift_type = 2'($urandom_range(0, 3));
        carry_in = 1'($urandom_range(0, 1));
      end
      if (done) begin start = 1'b0; got = 1; end
      else start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
    end
    if (!got) begin
      checks++; errors++; start = 1'b0;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask

  initial begin
    exp_t e;
    fork
      begin : monitor
        forever begin
          @(negedge clk);
          if (rst && done) begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
            end else begin
              e = exp_q.pop_front();
              chk("result", result, e.res);
              chk("carry_out", 32'(carry_out), 32'(e.c));
              chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
          end
        end
      end
      begin : stimulus
        #1;
        chk("rst_result", result, 32'd0);
        chk("rst_carry", 32'(carry_out), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
        chk("rst_perf", 32'(stall_cycles), 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // LSL 1 by 4 with an explicit stall profile
        issue(32'h0000_0001, 8'd4, 2'd0, 1'b0, 1);
        @(negedge clk); start = 1'b0;
        #1 chk("stall_cyc1", 32'(stall), 32'd1);
        @(negedge clk);
        #1 chk("stall_cyc2", 32'(stall), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
        chk("perf_count", 32'(stall_cycles), 32'd2);
`endif

        // Boundary cases
        issue(32'h8000_0000, 8'd32,  2'd1, 1'b0, 1); wait_done(0);
        issue(32'hFFFF_FFFF, 8'd40,  2'd0, 1'b1, 1); wait_done(0);
        issue(32'h8000_0000, 8'd200, 2'd2, 1'b0, 1); wait_done(0);
        issue(32'h0000_00F1, 8'd36,  2'd3, 1'b0, 1); wait_done(0);
        issue(32'h8765_4321, 8'd64,  2'd3, 1'b0, 1); wait_done(0);
        issue(32'h1234_5678, 8'd0,   2'd0, 1'b1, 1);
        @(negedge clk); start = 1'b0;
        #1 chk("stall_zero_cnt", 32'(stall), 32'd0);
        @(negedge clk);

        // Flush mid-shift, with a start in cycle 2 that must be ignored
        issue(32'hDEAD_BEEF, 8'd20, 2'd0, 1'b0, 0);
        @(negedge clk); start = 1'b0;
        @(negedge clk); start = 1'b1; rm = 32'h0; shift_type = 2'd3;
        #1 chk("busy_cyc2", 32'(busy), 32'd1);
        @(negedge clk); start = 1'b0; flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        #1 chk("flush_idle", 32'(busy), 32'd0);
        chk("flush_stall", 32'(stall), 32'd0);
        repeat (8) @(negedge clk);

        // When start and flush are both high in IDLE, flush wins
        start = 1'b1; flush = 1'b1;
        #1 chk("flush_prio_stall", 32'(stall), 32'd0);
        @(negedge clk); start = 1'b0; flush = 1'b0;
        #1 chk("flush_prio_busy", 32'(busy), 32'd0);

        issue(32'h0000_0F00, 8'd8, 2'd1, 1'b0, 1); wait_done(1);

        // Random traffic, with start toggling while busy
        for (int i = 0; i < 60; i++) begin
          logic [7:0] amt;
          amt = ($urandom_range(0, 1) != 0) ? 8'($urandom) : 8'($urandom_range(0, 40));
          issue($urandom, amt, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1);
          wait_done(1);
        end

        // Async reset mid-SHIFT
        issue(32'hA5A5_A5A5, 8'd20, 2'd0, 1'b1, 0);
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        #2 rst = 1'b0;
        #1 chk("arst_result", result, 32'd0);
        chk("arst_carry", 32'(carry_out), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_stall", 32'(stall), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
`ifdef REG_SHIFT_SEQ_PERF_CNT_EN
        #1 chk("arst_perf", 32'(stall_cycles), 32'd0);
`endif
        repeat (10) @(negedge clk);
        chk("post_arst_busy", 32'(busy), 32'd0);
        issue(32'h0000_0003, 8'd1, 2'd3, 1'b0, 1); wait_done(0);
        repeat (3) @(negedge clk);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
      end
    join_any
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
